// File: rtl/ysyx_22051468_divider_multicycle_if.sv
// ----------------------------------------------------------------------------
// ysyx_22051468_divider_multicycle_if
// Operand/result channel between the EXU (master) and the multi-cycle
// divider (slave).
//
// Signals
//   in_valid      master -> slave  request valid
//   in_ready      slave  -> master request ready (divider idle)
//   in_op1        master -> slave  dividend
//   in_op2        master -> slave  divisor
//   in_is_signed  master -> slave  1 = DIV/REM[W], 0 = DIVU/REMU[W]
//   in_is_rem     master -> slave  1 = remainder, 0 = quotient
//   in_is_w       master -> slave  1 = 32-bit W operation
//   flush_i       master -> slave  abort the operation in flight
//   out_valid     slave  -> master result valid
//   out_ready     master -> slave  consumer accepts the result
//   out_result    slave  -> master quotient or remainder
// ----------------------------------------------------------------------------
interface ysyx_22051468_divider_multicycle_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_op1;
    logic [WIDTH-1:0] in_op2;
    logic             in_is_signed;
    logic             in_is_rem;
    logic             in_is_w;
    logic             flush_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;

    modport master (
        output in_valid, in_op1, in_op2, in_is_signed, in_is_rem, in_is_w,
               flush_i, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_op1, in_op2, in_is_signed, in_is_rem, in_is_w,
               flush_i, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/ysyx_22051468_divider_multicycle.sv
// ----------------------------------------------------------------------------
// ysyx_22051468_divider_multicycle
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their
// W variants. One request is accepted per in_valid/in_ready handshake and one
// result returned per out_valid/out_ready handshake.
//
// Ports
//   clk    clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    ysyx_22051468_divider_multicycle_if.slave (request/result channel)
//
// Configuration
//   YSYX_22051468_DIV_W_FAST_EN  when defined, W operations iterate only
//   WIDTH/2 times on the 32-bit operands (34-cycle latency instead of 66).
//   Results are identical either way.
// ----------------------------------------------------------------------------
module ysyx_22051468_divider_multicycle #(
    parameter int WIDTH     = 64,
    parameter int CNT_WIDTH = 7
) (
    input  logic                               clk,
    input  logic                               rst_n,
    ysyx_22051468_divider_multicycle_if.slave  bus
);
    localparam int                   HALF      = WIDTH / 2;
    localparam logic [CNT_WIDTH-1:0] ITER_FULL = CNT_WIDTH'(WIDTH);
`ifdef YSYX_22051468_DIV_W_FAST_EN
    localparam logic [CNT_WIDTH-1:0] ITER_HALF = CNT_WIDTH'(HALF);
`endif
    localparam logic [WIDTH-1:0]     MIN_FULL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [HALF-1:0]      MIN_HALF  = {1'b1, {(HALF-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [WIDTH:0]       rem;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     divisor;
    logic                 q_neg;
    logic                 r_neg;
    logic                 is_rem;
    logic                 is_w;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     out_result_q;

    function automatic logic [WIDTH-1:0] sext_half(input logic [HALF-1:0] v);
        return {{(WIDTH-HALF){v[HALF-1]}}, v};
    endfunction

    // Request decode: widen W operands, take magnitudes and detect the two
    // cases that bypass the iteration (divide by zero and signed overflow).
    logic [WIDTH-1:0] ext_op1;
    logic [WIDTH-1:0] ext_op2;
    logic [WIDTH-1:0] abs_op1;
    logic [WIDTH-1:0] abs_op2;
    logic             sign_op1;
    logic             sign_op2;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] special_raw;
    logic [WIDTH-1:0] special_result;

    always_comb begin
        ext_op1 = bus.in_op1;
        ext_op2 = bus.in_op2;
        if (bus.in_is_w) begin
            ext_op1 = bus.in_is_signed ? sext_half(bus.in_op1[HALF-1:0])
                                       : {{(WIDTH-HALF){1'b0}}, bus.in_op1[HALF-1:0]};
            ext_op2 = bus.in_is_signed ? sext_half(bus.in_op2[HALF-1:0])
                                       : {{(WIDTH-HALF){1'b0}}, bus.in_op2[HALF-1:0]};
        end
        sign_op1 = bus.in_is_signed & ext_op1[WIDTH-1];
        sign_op2 = bus.in_is_signed & ext_op2[WIDTH-1];
        abs_op1  = sign_op1 ? -ext_op1 : ext_op1;
        abs_op2  = sign_op2 ? -ext_op2 : ext_op2;
        div_zero = (ext_op2 == '0);
        // Overflow is judged at the operation's own width: a W MIN/-1 pair is
        // not MIN/-1 once sign-extended to the full datapath.
        overflow = bus.in_is_signed &&
                   (bus.in_is_w ? (bus.in_op1[HALF-1:0] == MIN_HALF && bus.in_op2[HALF-1:0] == '1)
                                : (bus.in_op1 == MIN_FULL && bus.in_op2 == '1));
        special_raw = '0;
        if (div_zero) begin
            special_raw = bus.in_is_rem ? bus.in_op1 : '1;
        end else if (overflow) begin
            special_raw = bus.in_is_rem ? '0 : bus.in_op1;
        end
        special_result = bus.in_is_w ? sext_half(special_raw[HALF-1:0]) : special_raw;
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The top remainder bit is
    // folded into the compare so the step stays correct without relying on
    // it being zero.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             step_ge;

    always_comb begin
        rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, divisor};
        step_ge   = rem[WIDTH] | ~rem_diff[WIDTH];
        rem_next  = step_ge ? rem_diff : rem_shift;
        quo_next  = {quo[WIDTH-2:0], step_ge};
    end

    // Final correction: restore signs, pick quotient or remainder and
    // sign-extend W results from bit 31 (unsigned W ops included).
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] fix_raw;
    logic [WIDTH-1:0] fix_result;

    always_comb begin
        q_fix      = q_neg ? -quo : quo;
        r_fix      = r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        fix_raw    = is_rem ? r_fix : q_fix;
        fix_result = is_w ? sext_half(fix_raw[HALF-1:0]) : fix_raw;
    end

    // Control FSM and datapath registers. A flush wins over every handshake
    // and simply drops whatever is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rem          <= '0;
            quo          <= '0;
            divisor      <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            is_rem       <= 1'b0;
            is_w         <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else if (bus.flush_i) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        is_rem     <= bus.in_is_rem;
                        is_w       <= bus.in_is_w;
                        in_ready_q <= 1'b0;
                        if (div_zero || overflow) begin
                            out_result_q <= special_result;
                            out_valid_q  <= 1'b1;
                            state        <= DONE;
                        end else begin
                            q_neg   <= sign_op1 ^ sign_op2;
                            r_neg   <= sign_op1;
                            divisor <= abs_op2;
                            rem     <= '0;
                            quo     <= abs_op1;
                            cnt     <= ITER_FULL;
`ifdef YSYX_22051468_DIV_W_FAST_EN
                            // Park the 32-bit dividend in the upper half so
                            // its MSB is the first bit shifted out.
                            if (bus.in_is_w) begin
                                quo <= {abs_op1[HALF-1:0], {(WIDTH-HALF){1'b0}}};
                                cnt <= ITER_HALF;
                            end
`endif
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_WIDTH'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    out_result_q <= fix_result;
                    out_valid_q  <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
endmodule

// File: tb/tb_ysyx_22051468_divider_multicycle.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22051468_divider_multicycle
// Scoreboard bench for the multi-cycle divider: requests push their expected
// result and first-valid cycle into a queue, a negedge monitor pops and
// compares on every result handshake.
// ----------------------------------------------------------------------------
module tb_ysyx_22051468_divider_multicycle;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ysyx_22051468_divider_multicycle_if #(.WIDTH(64)) bus();

    ysyx_22051468_divider_multicycle #(
        .WIDTH     (64),
        .CNT_WIDTH (7)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] result;
        int          valid_cycle;
    } exp_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        bit          s;
        bit          r;
        bit          w;
        logic [63:0] e;
    } vec_t;

    exp_t exp_q[$];
    int   tests_run  = 0;
    int   fail_count = 0;
    int   cyc        = 0;
    bit   seen_valid = 1'b0;
    int   ready_mode = 0;

    always @(posedge clk) cyc++;

    // out_ready has a single driver: 0 = random, 1 = held low, 2 = held high
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = ($urandom_range(0, 3) != 0);
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'b1;
        endcase
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    // Reference model straight from the RISC-V division rules
    function automatic logic [63:0] refModel(input logic [63:0] a, input logic [63:0] b,
                                             input bit s, input bit r, input bit w);
        logic [31:0] a32;
        logic [31:0] b32;
        logic [31:0] r32;
        logic [63:0] r64;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0)                                          r32 = r ? a32 : 32'hFFFF_FFFF;
            else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = r ? 32'd0 : a32;
            else if (s)  r32 = r ? 32'($signed(a32) % $signed(b32)) : 32'($signed(a32) / $signed(b32));
            else         r32 = r ? a32 % b32 : a32 / b32;
            return {{32{r32[31]}}, r32};
        end
        if (b == 64'd0)                                                          r64 = r ? a : '1;
        else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r64 = r ? 64'd0 : a;
        else if (s)  r64 = r ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
        else         r64 = r ? a % b : a / b;
        return r64;
    endfunction

    function automatic int expectedLatency(input logic [63:0] a, input logic [63:0] b,
                                           input bit s, input bit w);
        bit special;
        if (w) special = (b[31:0] == 32'd0) || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        else   special = (b == 64'd0) || (s && a == 64'h8000_0000_0000_0000 && b == '1);
        if (special) return 1;
`ifdef YSYX_22051468_DIV_W_FAST_EN
        if (w) return 34;
`endif
        return 66;
    endfunction

    function automatic logic [63:0] pickOperand();
        logic [63:0] v;
        case ($urandom_range(0, 6))
            0:       v = {$urandom(), $urandom()};
            1:       v = 64'($urandom_range(0, 20));
            2:       v = -64'($urandom_range(1, 20));
            3:       v = 64'h8000_0000_0000_0000;
            4:       v = '1;
            5:       v = {$urandom(), 32'h8000_0000};
            default: v = {$urandom(), $urandom()} >> $urandom_range(0, 63);
        endcase
        return v;
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; waits for in_ready, presents one request for one
    // cycle and scrambles the inputs afterwards to prove they were latched.
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                                 input bit s, input bit r, input bit w, input logic [63:0] expected);
        int waited = 0;
        exp_t item;
        while (bus.in_ready !== 1'b1 && waited < 300) begin
            waitCycles(1);
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            tests_run++;
            fail_count++;
            $display("[TB] FAIL accept_timeout: got in_ready=%b, expected 1 within 300 cycles", bus.in_ready);
            return;
        end
        bus.in_op1       = a;
        bus.in_op2       = b;
        bus.in_is_signed = s;
        bus.in_is_rem    = r;
        bus.in_is_w      = w;
        bus.in_valid     = 1'b1;
        item.result      = expected;
        item.valid_cycle = cyc + expectedLatency(a, b, s, w);
        exp_q.push_back(item);
        waitCycles(1);
        bus.in_valid     = 1'b0;
        bus.in_op1       = {$urandom(), $urandom()};
        bus.in_op2       = {$urandom(), $urandom()};
        bus.in_is_signed = 1'($urandom());
        bus.in_is_rem    = 1'($urandom());
        bus.in_is_w      = 1'($urandom());
    endtask

    task automatic drainQueue(input int limit);
        int waited = 0;
        while (exp_q.size() != 0 && waited < limit) begin
            waitCycles(1);
            waited++;
        end
        checkOutput("drain_queue", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: first valid cycle checks latency and value, every valid cycle
    // checks in_ready is low, each handshake checks the held value and pops.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                fail_count++;
                $display("[TB] FAIL unexpected_valid: got out_valid=1 result 0x%h, expected no output", bus.out_result);
            end else begin
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    checkOutput("latency_cycle", 64'(cyc), 64'(exp_q[0].valid_cycle));
                    checkOutput("result_first", bus.out_result, exp_q[0].result);
                end
                checkOutput("in_ready_in_done", {63'd0, bus.in_ready}, 64'd0);
                if (bus.out_ready) begin
                    checkOutput("result_handshake", bus.out_result, exp_q[0].result);
                    void'(exp_q.pop_front());
                    seen_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got no finish, expected finish within 60000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[14];
        logic [63:0] a;
        logic [63:0] b;
        bit          s;
        bit          r;
        bit          w;

        bus.in_valid     = 1'b0;
        bus.in_op1       = '0;
        bus.in_op2       = '0;
        bus.in_is_signed = 1'b0;
        bus.in_is_rem    = 1'b0;
        bus.in_is_w      = 1'b0;
        bus.flush_i      = 1'b0;

        waitCycles(3);
        checkOutput("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        checkOutput("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("reset_out_result", bus.out_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        waitCycles(1);

        vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2]  = '{64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3]  = '{64'd5, 64'd0, 1'b0, 1'b1, 1'b0, 64'd5};
        vecs[4]  = '{64'd5, 64'd0, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000};
        vecs[6]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 64'd0};
        vecs[7]  = '{64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000};
        vecs[8]  = '{64'h0000_0000_FFFF_FFFE, 64'd2, 1'b0, 1'b0, 1'b1, 64'h0000_0000_7FFF_FFFF};
        vecs[9]  = '{64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[10] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[11] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 1'b0, 1'b0, 64'h5555_5555_5555_5555};
        vecs[12] = '{64'hDEAD_BEEF_0000_0007, 64'h0000_0000_FFFF_FFFE, 1'b1, 1'b1, 1'b1, 64'd1};
        vecs[13] = '{64'h1234_5678_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD};

        ready_mode = 0;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].w, vecs[i].e);
        end

        // Backpressure: result held for five cycles while a second request
        // waits on in_valid and must not be taken.
        ready_mode = 2;
        drainQueue(300);
        ready_mode = 1;
        waitCycles(2);
        applyStimulus(64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.in_op1       = 64'd100;
        bus.in_op2       = 64'd7;
        bus.in_is_signed = 1'b0;
        bus.in_is_rem    = 1'b0;
        bus.in_is_w      = 1'b0;
        bus.in_valid     = 1'b1;
        repeat (5) begin
            checkOutput("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
            checkOutput("bp_out_result", bus.out_result, 64'hFFFF_FFFF_FFFF_FFFF);
            checkOutput("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
            waitCycles(1);
        end
        bus.in_valid = 1'b0;
        ready_mode   = 2;
        applyStimulus(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14);
        drainQueue(300);

        // Asynchronous reset in the middle of an iteration
        applyStimulus(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD);
        waitCycles(5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        checkOutput("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("midrst_out_result", bus.out_result, 64'd0);
        exp_q.delete();
        seen_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        waitCycles(75);
        checkOutput("midrst_idle_after", {63'd0, bus.in_ready}, 64'd1);

        // Flush in cycle 10 of the iteration
        applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h1357, 1'b0, 1'b0, 1'b0,
                      refModel(64'h1234_5678_9ABC_DEF0, 64'h1357, 1'b0, 1'b0, 1'b0));
        waitCycles(9);
        bus.flush_i = 1'b1;
        exp_q.delete();
        seen_valid = 1'b0;
        waitCycles(1);
        bus.flush_i = 1'b0;
        checkOutput("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
        checkOutput("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
        waitCycles(75);
        checkOutput("flush_idle_after", {63'd0, bus.in_ready}, 64'd1);

        // Randomised operations under random backpressure
        ready_mode = 0;
        for (int n = 0; n < 40; n++) begin
            a = pickOperand();
            b = pickOperand();
            s = 1'($urandom());
            r = 1'($urandom());
            w = 1'($urandom());
            applyStimulus(a, b, s, r, w, refModel(a, b, s, r, w));
        end
        ready_mode = 2;
        drainQueue(300);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end
endmodule
